// File: rtl/status_flags_if.sv
// Signal bundle between the datapath/control FSM and the 6502 status register.
// The master drives ALU results and control strobes; the slave returns flags and branch status.
interface status_flags_if;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_ovf;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_op;
  logic [7:0] dbus_in;
  logic       ld_p;
  logic       ld_rti;
  logic [2:0] flag_op;
  logic       flag_op_en;
  logic       irq_ack;
  logic       brk_push;
  logic       instr_done;
  logic [2:0] cond_sel;
  logic       carry;
  logic       dec_mode;
  logic       irq_mask;
  logic       branch_tkn;
  logic [7:0] p_push;

  modport master (
    output alu_res, alu_cout, alu_ovf, upd_nz, upd_c, upd_v, bit_op,
           dbus_in, ld_p, ld_rti, flag_op, flag_op_en, irq_ack,
           brk_push, instr_done, cond_sel,
    input  carry, dec_mode, irq_mask, branch_tkn, p_push
  );

  modport slave (
    input  alu_res, alu_cout, alu_ovf, upd_nz, upd_c, upd_v, bit_op,
           dbus_in, ld_p, ld_rti, flag_op, flag_op_en, irq_ack,
           brk_push, instr_done, cond_sel,
    output carry, dec_mode, irq_mask, branch_tkn, p_push
  );
endinterface

// File: rtl/status_flags.sv
// 6502 processor status register: flag update priority, delayed IRQ mask,
// branch condition evaluation and the stack image of P.
module status_flags #(
  parameter bit         DECIMAL_EN = 1'b0,
  parameter logic [7:0] RESET_P    = 8'h04
) (
  input logic          clk,
  input logic          rst,
  status_flags_if.slave bus
);

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic [2:0] {
    OP_CLC  = 3'd0,
    OP_SEC  = 3'd1,
    OP_CLI  = 3'd2,
    OP_SEI  = 3'd3,
    OP_CLV  = 3'd4,
    OP_CLD  = 3'd5,
    OP_SED  = 3'd6,
    OP_NONE = 3'd7
  } flag_op_t;

  typedef enum logic [2:0] {
    C_BPL = 3'd0,
    C_BMI = 3'd1,
    C_BVC = 3'd2,
    C_BVS = 3'd3,
    C_BCC = 3'd4,
    C_BCS = 3'd5,
    C_BNE = 3'd6,
    C_BEQ = 3'd7
  } cond_t;

  // Bits 5 and 4 of a P byte have no storage and are dropped.
  function automatic flags_t byte_to_flags(input logic [7:0] b);
    flags_t f;
    f.n = b[7];
    f.v = b[6];
    f.d = b[3];
    f.i = b[2];
    f.z = b[1];
    f.c = b[0];
    return f;
  endfunction

  localparam flags_t RESET_FLAGS = byte_to_flags(RESET_P);

  flags_t flags;
  flags_t flags_nxt;
  logic   irq_mask_q;
  logic   irq_mask_nxt;
  logic   res_zero;
  logic   unused_bits;

  assign res_zero    = (bus.alu_res == 8'h00);
  assign unused_bits = ^bus.dbus_in[5:4];

  // Lowest-priority sources are applied first so later ones overwrite them.
  always_comb begin
    flags_nxt = flags;

    if (bus.upd_nz) begin
      flags_nxt.n = bus.alu_res[7];
      flags_nxt.z = res_zero;
    end
    if (bus.upd_v) flags_nxt.v = bus.alu_ovf;
    if (bus.upd_c) flags_nxt.c = bus.alu_cout;
    if (bus.bit_op) begin
      flags_nxt.n = bus.dbus_in[7];
      flags_nxt.v = bus.dbus_in[6];
      flags_nxt.z = res_zero;
    end

    if (bus.flag_op_en) begin
      case (flag_op_t'(bus.flag_op))
        OP_CLC:  flags_nxt.c = 1'b0;
        OP_SEC:  flags_nxt.c = 1'b1;
        OP_CLI:  flags_nxt.i = 1'b0;
        OP_SEI:  flags_nxt.i = 1'b1;
        OP_CLV:  flags_nxt.v = 1'b0;
        OP_CLD:  flags_nxt.d = 1'b0;
        OP_SED:  flags_nxt.d = 1'b1;
        default: ;
      endcase
    end

    if (bus.ld_p) flags_nxt = byte_to_flags(bus.dbus_in);

    if (bus.irq_ack) flags_nxt.i = 1'b1;
  end

  // The poll mask trails I by one instruction except for RTI and interrupt entry.
  always_comb begin
    irq_mask_nxt = irq_mask_q;
    if (bus.instr_done)            irq_mask_nxt = flags.i;
    if (bus.ld_p && bus.ld_rti)    irq_mask_nxt = bus.dbus_in[2];
    if (bus.irq_ack)               irq_mask_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags      <= RESET_FLAGS;
      irq_mask_q <= 1'b1;
    end else begin
      flags      <= flags_nxt;
      irq_mask_q <= irq_mask_nxt;
    end
  end

  always_comb begin
    bus.branch_tkn = 1'b0;
    case (cond_t'(bus.cond_sel))
      C_BPL:   bus.branch_tkn = ~flags.n;
      C_BMI:   bus.branch_tkn =  flags.n;
      C_BVC:   bus.branch_tkn = ~flags.v;
      C_BVS:   bus.branch_tkn =  flags.v;
      C_BCC:   bus.branch_tkn = ~flags.c;
      C_BCS:   bus.branch_tkn =  flags.c;
      C_BNE:   bus.branch_tkn = ~flags.z;
      C_BEQ:   bus.branch_tkn =  flags.z;
      default: bus.branch_tkn = 1'b0;
    endcase
  end

  assign bus.carry    = flags.c;
  assign bus.dec_mode = DECIMAL_EN ? flags.d : 1'b0;
  assign bus.irq_mask = irq_mask_q;
  assign bus.p_push   = {flags.n, flags.v, 1'b1, bus.brk_push,
                         flags.d, flags.i, flags.z, flags.c};

endmodule
